// File: rtl/dkong_audio_pkg.sv
// -----------------------------------------------------------------------------
// dkong_audio_pkg
// Shared definitions for the Donkey Kong sound path. The DAC post-processing
// block and the downstream audio mixer both import this package.
//
// Contents:
//   DAC_W         width of the 8035 port-A DAC code
//   SMP_W         width of the signed PCM sample stream
//   ENV_FULL      envelope value meaning "no attenuation"
//   sample_t      signed PCM sample type used between audio blocks
//   dac_to_signed removes the mid-scale offset from an unsigned DAC code
// -----------------------------------------------------------------------------
package dkong_audio_pkg;

  localparam int DAC_W = 8;
  localparam int SMP_W = 16;

  localparam logic [DAC_W-1:0] ENV_FULL = 8'hFF;

  // Signed PCM sample exchanged between the filter and the mixer.
  typedef logic signed [SMP_W-1:0] sample_t;

  // The DAC idles at mid-scale (0x80). Flipping the MSB turns the unsigned
  // code into a two's-complement value equal to code - 128, so 0x80 becomes
  // 0, 0xFF becomes +127 and 0x00 becomes -128.
  function automatic logic signed [DAC_W-1:0] dac_to_signed(
    input logic [DAC_W-1:0] code
  );
    logic signed [DAC_W-1:0] res;
    res = {~code[DAC_W-1], code[DAC_W-2:0]};
    return res;
  endfunction

endpackage : dkong_audio_pkg

// File: rtl/dkong_iir_lp.sv
// -----------------------------------------------------------------------------
// dkong_iir_lp
// One-pole IIR low-pass:  y <= y + ((x - y) >>> K_SHIFT), evaluated only on
// cycles where en is high. It models a simple RC output network. The same
// block is meant to be reused on the DK Jr. analog voice paths.
//
// Parameters:
//   K_SHIFT  coefficient exponent, alpha = 2^-K_SHIFT (0 = pass-through)
//
// Ports:
//   clk  in   clock
//   rst  in   asynchronous reset, active-high, clears the filter state
//   en   in   update strobe, one cycle per sample
//   x    in   signed filter input
//   y    out  signed filter state (registered, holds between strobes)
// -----------------------------------------------------------------------------
module dkong_iir_lp
  import dkong_audio_pkg::*;
#(
  parameter int K_SHIFT = 3
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    en,
  input  sample_t x,
  output sample_t y
);

  // One extra bit holds x - y without wrap for any pair of 16-bit samples.
  logic signed [SMP_W:0] diff_s;
  logic signed [SMP_W:0] step_s;
  sample_t               y_r;

  // Difference and coefficient scaling. The arithmetic shift rounds toward
  // minus infinity, so the step magnitude never exceeds |x - y| and the
  // 16-bit sum below cannot overflow.
  always_comb begin
    diff_s = {x[SMP_W-1], x} - {y_r[SMP_W-1], y_r};
    step_s = diff_s >>> K_SHIFT;
  end

  // Filter state, advanced once per strobe and held otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_r <= {SMP_W{1'b0}};
    end else if (en) begin
      y_r <= y_r + step_s[SMP_W-1:0];
    end else begin
      y_r <= y_r;
    end
  end

  assign y = y_r;

endmodule : dkong_iir_lp

// File: rtl/dkong_dac_filter.sv
// -----------------------------------------------------------------------------
// dkong_dac_filter
// Converts the 8035 port-A DAC code into a signed 16-bit PCM stream at a
// fixed sample rate of I_CLK / CLK_DIV.
//
// Chain (one pass per sample tick):
//   registered DAC code -> offset removal -> envelope scale (or forced 0 when
//   muted) -> x register -> one-pole low-pass -> O_SAMPLE
//
// Parameters:
//   CLK_DIV    I_CLK cycles per output sample (>= 2)
//   K_SHIFT    low-pass coefficient exponent (0..8, 0 = pass-through)
//   DECAY_DIV  sample ticks per envelope decrement (>= 1)
//
// Ports:
//   I_CLK         in   system clock
//   I_RST         in   asynchronous reset, active-high
//   I_DAC_DAT     in   unsigned DAC code from 8035 port A
//   I_DECAY_EN    in   1 = envelope decays, 0 = envelope held at full scale
//   I_MUTE        in   1 = filter input forced to 0 (output decays, no click)
//   O_SAMPLE      out  signed filtered sample, holds between strobes
//   O_SAMPLE_VLD  out  one-cycle strobe marking a new O_SAMPLE
//
// Timing: the tick cycle is the one where the sample counter reads
// CLK_DIV-1. The edge closing it loads x; the next edge updates the filter,
// which drives O_SAMPLE directly, and raises O_SAMPLE_VLD for one cycle.
// -----------------------------------------------------------------------------
module dkong_dac_filter
  import dkong_audio_pkg::*;
#(
  parameter int CLK_DIV   = 48,
  parameter int K_SHIFT   = 3,
  parameter int DECAY_DIV = 256
) (
  input  logic                     I_CLK,
  input  logic                     I_RST,
  input  logic [DAC_W-1:0]         I_DAC_DAT,
  input  logic                     I_DECAY_EN,
  input  logic                     I_MUTE,
  output logic signed [SMP_W-1:0]  O_SAMPLE,
  output logic                     O_SAMPLE_VLD
);

  // Counter widths; a divide of 1 still needs a one-bit register.
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PW = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;

  localparam logic [CW-1:0] CNT_LAST   = CW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(DECAY_DIV - 1);

  // Registered copies of the inputs; nothing downstream looks at the pins.
  logic [DAC_W-1:0] dac_r;
  logic             decay_r;
  logic             mute_r;

  // Sample-rate tick generation.
  logic [CW-1:0]    cnt_r;
  logic             tick_s;

  // Decay envelope.
  logic [PW-1:0]    presc_r;
  logic [DAC_W-1:0] env_r;

  // Scaling datapath.
  logic signed [DAC_W-1:0] code_s;
  sample_t                 code_ext_s;
  sample_t                 env_ext_s;
  sample_t                 scaled_s;

  // Pipeline registers.
  sample_t          x_r;
  logic             tick_d_r;
  logic             vld_r;
  sample_t          y_s;

  // Input capture stage.
  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) begin
      dac_r   <= {DAC_W{1'b0}};
      decay_r <= 1'b0;
      mute_r  <= 1'b0;
    end else begin
      dac_r   <= I_DAC_DAT;
      decay_r <= I_DECAY_EN;
      mute_r  <= I_MUTE;
    end
  end

  assign tick_s = (cnt_r == CNT_LAST);

  // Free-running sample counter, 0..CLK_DIV-1.
  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) begin
      cnt_r <= {CW{1'b0}};
    end else if (tick_s) begin
      cnt_r <= {CW{1'b0}};
    end else begin
      cnt_r <= cnt_r + CW'(1'b1);
    end
  end

  // Envelope update on the tick edge. With decay disabled the envelope is
  // pinned at full scale, so a 1->0 on decay retriggers it at the next tick.
  // The scale step in the same tick still sees the pre-update value.
  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) begin
      presc_r <= {PW{1'b0}};
      env_r   <= ENV_FULL;
    end else if (tick_s) begin
      if (!decay_r) begin
        presc_r <= {PW{1'b0}};
        env_r   <= ENV_FULL;
      end else if (presc_r == PRESC_LAST) begin
        presc_r <= {PW{1'b0}};
        env_r   <= (env_r == {DAC_W{1'b0}}) ? {DAC_W{1'b0}} : env_r - 8'd1;
      end else begin
        presc_r <= presc_r + PW'(1'b1);
        env_r   <= env_r;
      end
    end else begin
      presc_r <= presc_r;
      env_r   <= env_r;
    end
  end

  // Offset removal and envelope scaling. The signed 8 x unsigned 8 product
  // spans -32640..+32385, so the low 16 bits of a 16 x 16 multiply are the
  // exact result with no saturation required.
  always_comb begin
    code_s     = dac_to_signed(dac_r);
    code_ext_s = {{(SMP_W-DAC_W){code_s[DAC_W-1]}}, code_s};
    env_ext_s  = {{(SMP_W-DAC_W){1'b0}}, env_r};
    if (mute_r) begin
      scaled_s = {SMP_W{1'b0}};
    end else begin
      scaled_s = code_ext_s * env_ext_s;
    end
  end

  // Filter input register, loaded once per sample on the tick edge.
  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) begin
      x_r <= {SMP_W{1'b0}};
    end else if (tick_s) begin
      x_r <= scaled_s;
    end else begin
      x_r <= x_r;
    end
  end

  // Delayed tick: enables the filter one edge after x is loaded, and its
  // own delay is the output strobe. Reset clears both, dropping any
  // in-flight strobe.
  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) begin
      tick_d_r <= 1'b0;
      vld_r    <= 1'b0;
    end else begin
      tick_d_r <= tick_s;
      vld_r    <= tick_d_r;
    end
  end

  dkong_iir_lp #(
    .K_SHIFT (K_SHIFT)
  ) u_iir (
    .clk (I_CLK),
    .rst (I_RST),
    .en  (tick_d_r),
    .x   (x_r),
    .y   (y_s)
  );

  // The filter state is itself a register that only moves on the strobe
  // edge, so it serves directly as the held output sample.
  assign O_SAMPLE     = y_s;
  assign O_SAMPLE_VLD = vld_r;

endmodule : dkong_dac_filter

// File: tb/tb_dkong_dac_filter.sv
// -----------------------------------------------------------------------------
// tb_dkong_dac_filter
// Two instances share one stimulus: u_k0 (K_SHIFT=0) and u_k3 (K_SHIFT=3),
// both with CLK_DIV=4 and DECAY_DIV=2. A behavioural model computes the
// expected sample stream for both from plain integer arithmetic, and a
// compare process checks every cycle. Directed scenarios add hand-computed
// literal expectations.
// -----------------------------------------------------------------------------
module tb_dkong_dac_filter;

  localparam int CLK_DIV   = 4;
  localparam int DECAY_DIV = 2;

  logic                I_CLK = 1'b0;
  logic                I_RST = 1'b1;
  logic [7:0]          I_DAC_DAT = 8'h80;
  logic                I_DECAY_EN = 1'b0;
  logic                I_MUTE = 1'b0;
  logic signed [15:0]  s0;
  logic signed [15:0]  s3;
  logic                v0;
  logic                v3;

  int n_chk = 0;
  int n_err = 0;

  dkong_dac_filter #(.CLK_DIV(CLK_DIV), .K_SHIFT(0), .DECAY_DIV(DECAY_DIV)) u_k0 (
    .I_CLK(I_CLK), .I_RST(I_RST), .I_DAC_DAT(I_DAC_DAT), .I_DECAY_EN(I_DECAY_EN),
    .I_MUTE(I_MUTE), .O_SAMPLE(s0), .O_SAMPLE_VLD(v0)
  );

  dkong_dac_filter #(.CLK_DIV(CLK_DIV), .K_SHIFT(3), .DECAY_DIV(DECAY_DIV)) u_k3 (
    .I_CLK(I_CLK), .I_RST(I_RST), .I_DAC_DAT(I_DAC_DAT), .I_DECAY_EN(I_DECAY_EN),
    .I_MUTE(I_MUTE), .O_SAMPLE(s3), .O_SAMPLE_VLD(v3)
  );

  always #5 I_CLK = ~I_CLK;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Floor division by 2^k on integers (round toward minus infinity).
  function automatic int floor_div_pow2(input int d, input int k);
    int p;
    p = 1 << k;
    if (d >= 0) return d / p;
    return -((-d + p - 1) / p);
  endfunction

  // ---------------- behavioural model ----------------
  int m_cnt = 0, m_presc = 0, m_env = 255;
  int m_dac = 0, m_dec = 0, m_mute = 0;
  int m_x = 0, m_y0 = 0, m_y3 = 0;
  bit m_pend = 1'b0, m_vld = 1'b0;

  initial begin
    forever begin
      @(posedge I_CLK or posedge I_RST);
      if (I_RST) begin
        m_cnt = 0; m_presc = 0; m_env = 255;
        m_dac = 0; m_dec = 0; m_mute = 0;
        m_x = 0; m_y0 = 0; m_y3 = 0; m_pend = 1'b0; m_vld = 1'b0;
      end else begin
        // Filter and strobe for the sample whose x was taken last edge.
        m_vld = m_pend;
        if (m_pend) begin
          m_y0 = m_y0 + floor_div_pow2(m_x - m_y0, 0);
          m_y3 = m_y3 + floor_div_pow2(m_x - m_y3, 3);
        end
        m_pend = (m_cnt == CLK_DIV - 1);
        if (m_pend) begin
          m_x = (m_mute != 0) ? 0 : (m_dac - 128) * m_env;
          if (m_dec == 0) begin
            m_env = 255; m_presc = 0;
          end else begin
            m_presc = m_presc + 1;
            if (m_presc == DECAY_DIV) begin
              m_presc = 0;
              if (m_env > 0) m_env = m_env - 1;
            end
          end
        end
        m_cnt = (m_cnt + 1) % CLK_DIV;
        m_dac = int'(I_DAC_DAT); m_dec = int'(I_DECAY_EN); m_mute = int'(I_MUTE);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge I_CLK);
      chk("k0_sample", int'(s0), m_y0);
      chk("k3_sample", int'(s3), m_y3);
      chk("k0_vld", int'(v0), int'(m_vld));
      chk("k3_vld", int'(v3), int'(m_vld));
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Waits (bounded) for the next strobe, observed at a falling edge.
  task automatic wait_vld(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge I_CLK);
      if (v0) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk({tag, "_timeout"}, int'(seen), 1);
  endtask

  // Counts rising edges from reset release until the first strobe.
  task automatic first_vld_edges(output int n);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge I_CLK);
      #1;
      if (v0) begin
        n = i;
        break;
      end
    end
  endtask

  int n, prev, pre;
  bit found;

  initial begin
    // 1. Reset and cadence.
    repeat (3) @(negedge I_CLK);
    chk("rst_sample", int'(s0), 0);
    chk("rst_vld", int'(v0), 0);
    I_RST = 1'b0;
    first_vld_edges(n);
    chk("first_vld_edges", n, 5);
    chk("idle_sample", int'(s0), 0);
    @(posedge I_CLK); #1;
    chk("vld_width", int'(v0), 0);
    n = 1;
    for (int i = 0; i < 10; i++) begin
      if (v0) break;
      @(posedge I_CLK); #1;
      n++;
    end
    chk("vld_period", n, 4);
    repeat (20) @(negedge I_CLK);

    // 2/4. Step 0x80 -> 0xFF: K=0 jumps to full scale, K=3 rises.
    I_DAC_DAT = 8'hFF;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_vld("step");
      if (s0 != 16'sd0) begin found = 1'b1; break; end
    end
    chk("k0_ff", int'(s0), 32385);
    chk("k3_first", int'(s3), 4048);
    prev = int'(s3);
    for (int i = 0; i < 100; i++) begin
      wait_vld("rise");
      chk("k3_monotonic", int'(int'(s3) >= prev), 1);
      prev = int'(s3);
    end
    chk("k3_settle", int'(s3 >= 16'sd32378 && s3 <= 16'sd32385), 1);

    // 5. Mute from steady state: strictly falling to exactly 0.
    pre = int'(s3);
    I_MUTE = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_vld("mute_start");
      if (int'(s3) != pre) break;
    end
    chk("k0_muted", int'(s0), 0);
    prev = pre;
    for (int i = 0; i < 200; i++) begin
      chk("mute_decreasing", int'(int'(s3) < prev), 1);
      if (s3 == 16'sd0) break;
      prev = int'(s3);
      wait_vld("mute");
    end
    chk("mute_zero", int'(s3), 0);
    I_MUTE = 1'b0;
    repeat (3) wait_vld("unmute");
    chk("unmute_rise", int'(s3 > 16'sd0), 1);

    // 2. Remaining offset/scale points with decay off.
    I_DAC_DAT = 8'h00;
    repeat (3) wait_vld("dac00");
    chk("k0_dac00", int'(s0), -32640);
    I_DAC_DAT = 8'h81;
    repeat (3) wait_vld("dac81");
    chk("k0_dac81", int'(s0), 255);

    // 3. Decay envelope.
    I_DAC_DAT = 8'hFF;
    repeat (3) wait_vld("pre_decay");
    chk("pre_decay_full", int'(s0), 32385);
    I_DECAY_EN = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wait_vld("decay_first");
      if (s0 != 16'sd32385) break;
    end
    chk("decay_first_step", int'(s0), 32258);
    for (int i = 0; i < 600; i++) begin
      if (s0 == 16'sd0) break;
      wait_vld("decay");
    end
    chk("decay_zero", int'(s0), 0);
    repeat (5) wait_vld("decay_hold");
    chk("decay_stays_zero", int'(s0), 0);
    I_DECAY_EN = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_vld("retrigger");
      if (s0 == 16'sd32385) begin found = 1'b1; break; end
    end
    chk("retrigger_full", int'(s0), 32385);

    // 6. Async reset between tick and strobe, with a decayed envelope.
    I_DECAY_EN = 1'b1;
    repeat (20) wait_vld("decay_again");
    chk("decayed_before_reset", int'(s0 < 16'sd32385 && s0 > 16'sd0), 1);
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge I_CLK);
      if (m_pend) begin found = 1'b1; break; end
    end
    chk("pend_window_found", int'(found), 1);
    #1 I_RST = 1'b1;
    #1;
    chk("async_rst_sample", int'(s0), 0);
    chk("async_rst_vld", int'(v0), 0);
    chk("async_rst_k3", int'(s3), 0);
    @(posedge I_CLK); #1;
    chk("no_vld_in_reset", int'(v0), 0);
    @(negedge I_CLK);
    I_RST = 1'b0;
    first_vld_edges(n);
    chk("post_rst_first_edges", n, 5);
    chk("post_rst_env_full", int'(s0), 32385);
    chk("post_rst_k3_first", int'(s3), 4048);

    repeat (4) @(negedge I_CLK);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule : tb_dkong_dac_filter
